// File: rtl/seq_detect_param.sv
// Serial sequence detector: tracks the longest matched prefix of PATTERN,
// emits a registered one-cycle match pulse and keeps a saturating match count.
module seq_detect_param #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = 8,
    parameter int               SW      = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inp,
    input  logic             in_valid,
    input  logic             clr,
    output logic [SW-1:0]    outputState,
    output logic             out,
    output logic [CNT_W-1:0] match_count
);

    typedef logic [SW-1:0] state_t;
    localparam state_t FULL = SW'(PAT_W);

    // Elaboration-time KMP step: longest suffix of (prefix_k, b) that is a prefix of PATTERN.
    function automatic int kmp_next(input int k, input logic b);
        int   kk, len, best, i;
        logic ok, sb;
        kk   = (k == PAT_W && !OVERLAP) ? 0 : k;
        len  = kk + 1;
        best = 0;
        for (int j = 1; j <= PAT_W; j++) begin
            if (j <= len) begin
                ok = 1'b1;
                for (int t = 0; t < j; t++) begin
                    i = len - j + t;
                    if (i == kk) sb = b;
                    else         sb = PATTERN[PAT_W-1-i];
                    if (sb != PATTERN[PAT_W-1-t]) ok = 1'b0;
                end
                if (ok) best = j;
            end
        end
        return best;
    endfunction

    state_t nxt_tab [PAT_W+1][2];

    for (genvar k = 0; k <= PAT_W; k++) begin : g_row
        for (genvar b = 0; b < 2; b++) begin : g_col
            assign nxt_tab[k][b] = SW'(kmp_next(k, b != 0));
        end
    end

    state_t           state_q, state_d, nxt_val;
    logic             out_q, out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= '0;
            out_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        nxt_val = '0;
        for (int k = 0; k <= PAT_W; k++) begin
            if (state_q == SW'(k)) nxt_val = nxt_tab[k][inp];
        end

        state_d = state_q;
        out_d   = 1'b0;
        cnt_d   = cnt_q;
        if (clr) begin
            state_d = '0;
            cnt_d   = '0;
        end else if (in_valid) begin
            state_d = nxt_val;
            // Every valid bit that lands in FULL is a fresh match, including self-overlap.
            if (nxt_val == FULL) begin
                out_d = 1'b1;
                if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign outputState = state_q;
    assign out         = out_q;
    assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: three configurations driven in parallel and
// compared against a bit-history model of longest matched prefix.
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       inp = 1'b0;
    logic       in_valid = 1'b0;
    logic       clr = 1'b0;
    logic [2:0] st_a, st_b;
    logic [1:0] st_c;
    logic       out_a, out_b, out_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;

    int checks = 0;
    int errors = 0;

    // a: defaults, b: non-overlapping, c: PATTERN=11 with 2-bit counter
    seq_detect_param u_a (.clk(clk), .rst(rst), .inp(inp), .in_valid(in_valid), .clr(clr),
                          .outputState(st_a), .out(out_a), .match_count(cnt_a));
    seq_detect_param #(.OVERLAP(1'b0)) u_b (.clk(clk), .rst(rst), .inp(inp), .in_valid(in_valid),
                          .clr(clr), .outputState(st_b), .out(out_b), .match_count(cnt_b));
    seq_detect_param #(.PAT_W(2), .PATTERN(2'b11), .CNT_W(2)) u_c (.clk(clk), .rst(rst), .inp(inp),
                          .in_valid(in_valid), .clr(clr), .outputState(st_c), .out(out_c),
                          .match_count(cnt_c));

    always #5 clk = ~clk;

    int          pw [3];
    int          ovl [3];
    int          cmax [3];
    logic [15:0] pt [3];
    logic [15:0] hb [3];
    int          hl [3];
    int          e_st [3];
    int          e_out [3];
    int          e_cnt [3];

    // Longest suffix of the accepted-bit history equal to a prefix of the pattern.
    function automatic int longest(input int i);
        logic [15:0] m;
        for (int j = (hl[i] < pw[i]) ? hl[i] : pw[i]; j >= 1; j--) begin
            m = 16'((32'd1 << j) - 1);
            if ((hb[i] & m) == ((pt[i] >> (pw[i] - j)) & m)) return j;
        end
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            hb[i] = '0; hl[i] = 0; e_st[i] = 0; e_out[i] = 0; e_cnt[i] = 0;
        end
    endtask

    task automatic model_step(input logic b, input logic v, input logic c);
        for (int i = 0; i < 3; i++) begin
            if (c) begin
                hb[i] = '0; hl[i] = 0; e_st[i] = 0; e_out[i] = 0; e_cnt[i] = 0;
            end else if (v) begin
                hb[i] = {hb[i][14:0], b};
                if (hl[i] < 16) hl[i]++;
                e_st[i]  = longest(i);
                e_out[i] = (e_st[i] == pw[i]) ? 1 : 0;
                if (e_out[i] == 1) begin
                    if (e_cnt[i] < cmax[i]) e_cnt[i]++;
                    if (ovl[i] == 0) hl[i] = 0;
                end
            end else begin
                e_out[i] = 0;
            end
        end
    endtask

    task automatic apply(input logic b, input logic v, input logic c);
        inp = b; in_valid = v; clr = c;
        @(posedge clk);
        model_step(b, v, c);
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        rst = 1'b0; inp = 1'b1; in_valid = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            checks++;
            if (st_a !== 3'd0 || out_a !== 1'b0 || cnt_a !== 8'd0 || st_b !== 3'd0 ||
                st_c !== 2'd0 || out_c !== 1'b0 || cnt_c !== 2'd0) begin
                errors++;
                $display("FAIL reset_hold: a=%0d/%0d/%0d c=%0d/%0d/%0d required all 0",
                         st_a, out_a, cnt_a, st_c, out_c, cnt_c);
            end
        end
        in_valid = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_overlap();
        logic [6:0] bits;
        int         tr_a [7];
        int         tr_b [7];
        bits = 7'b1011011;
        tr_a = '{1, 2, 3, 4, 2, 3, 4};
        tr_b = '{1, 2, 3, 4, 0, 1, 1};
        for (int n = 0; n < 7; n++) begin
            apply(bits[6-n], 1'b1, 1'b0);
            checks++;
            if (st_a !== 3'(tr_a[n]) || out_a !== (tr_a[n] == 4) || st_a !== 3'(e_st[0])) begin
                errors++;
                $display("FAIL overlap_trace bit%0d: state=%0d out=%0d required state=%0d out=%0d",
                         n + 1, st_a, out_a, tr_a[n], tr_a[n] == 4);
            end
            checks++;
            if (st_b !== 3'(tr_b[n]) || out_b !== (tr_b[n] == 4)) begin
                errors++;
                $display("FAIL nonoverlap_trace bit%0d: state=%0d out=%0d required state=%0d",
                         n + 1, st_b, out_b, tr_b[n]);
            end
        end
        checks++;
        if (cnt_a !== 8'd2 || cnt_b !== 8'd1) begin
            errors++;
            $display("FAIL overlap_count: a=%0d b=%0d required a=2 b=1", cnt_a, cnt_b);
        end
    endtask

    task automatic test_nonoverlap();
        logic [7:0] bits;
        bits = 8'b10111011;
        apply(1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 8; n++) begin
            apply(bits[7-n], 1'b1, 1'b0);
            checks++;
            if (st_b !== 3'(e_st[1]) || out_b !== 1'(e_out[1]) || cnt_b !== 8'(e_cnt[1])) begin
                errors++;
                $display("FAIL nonoverlap_step bit%0d: %0d/%0d/%0d required %0d/%0d/%0d",
                         n + 1, st_b, out_b, cnt_b, e_st[1], e_out[1], e_cnt[1]);
            end
        end
        checks++;
        if (cnt_b !== 8'd2) begin
            errors++;
            $display("FAIL nonoverlap_count: got %0d required 2", cnt_b);
        end
    endtask

    task automatic test_chain();
        logic [7:0] bits;
        int         tr [8];
        int         pulses;
        bits   = 8'b10101011;
        tr     = '{1, 2, 3, 2, 3, 2, 3, 4};
        pulses = 0;
        apply(1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 8; n++) begin
            apply(bits[7-n], 1'b1, 1'b0);
            if (out_a === 1'b1) pulses++;
            checks++;
            if (st_a !== 3'(tr[n]) || out_a !== (n == 7)) begin
                errors++;
                $display("FAIL chain_trace bit%0d: state=%0d out=%0d required state=%0d",
                         n + 1, st_a, out_a, tr[n]);
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL chain_pulses: got %0d required 1", pulses);
        end
    endtask

    task automatic test_gaps();
        apply(1'b0, 1'b0, 1'b1);
        apply(1'b1, 1'b1, 1'b0);
        apply(1'b0, 1'b1, 1'b0);
        for (int n = 0; n < 3; n++) begin
            apply(1'($urandom_range(1)), 1'b0, 1'b0);
            checks++;
            if (st_a !== 3'd2 || out_a !== 1'b0) begin
                errors++;
                $display("FAIL gap_hold idle%0d: state=%0d out=%0d required 2/0", n, st_a, out_a);
            end
        end
        apply(1'b1, 1'b1, 1'b0);
        checks++;
        if (st_a !== 3'd3 || out_a !== 1'b0) begin
            errors++;
            $display("FAIL gap_resume: state=%0d out=%0d required 3/0", st_a, out_a);
        end
        apply(1'b1, 1'b1, 1'b0);
        checks++;
        if (st_a !== 3'd4 || out_a !== 1'b1 || cnt_a !== 8'd1) begin
            errors++;
            $display("FAIL gap_match: %0d/%0d/%0d required 4/1/1", st_a, out_a, cnt_a);
        end
    endtask

    task automatic test_saturation();
        apply(1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 6; n++) begin
            apply(1'b1, 1'b1, 1'b0);
            checks++;
            if (st_c !== 2'(e_st[2]) || out_c !== 1'(e_out[2]) || cnt_c !== 2'(e_cnt[2])) begin
                errors++;
                $display("FAIL sat_step bit%0d: %0d/%0d/%0d required %0d/%0d/%0d",
                         n + 1, st_c, out_c, cnt_c, e_st[2], e_out[2], e_cnt[2]);
            end
        end
        checks++;
        if (cnt_c !== 2'd3) begin
            errors++;
            $display("FAIL sat_count: got %0d required 3", cnt_c);
        end
    endtask

    task automatic test_clr_priority();
        apply(1'b1, 1'b1, 1'b0);
        apply(1'b0, 1'b1, 1'b0);
        apply(1'b1, 1'b1, 1'b0);
        apply(1'b1, 1'b1, 1'b1);
        checks++;
        if (st_a !== 3'd0 || out_a !== 1'b0 || cnt_a !== 8'd0 ||
            st_c !== 2'd0 || out_c !== 1'b0 || cnt_c !== 2'd0) begin
            errors++;
            $display("FAIL clr_priority: a=%0d/%0d/%0d c=%0d/%0d/%0d required all 0",
                     st_a, out_a, cnt_a, st_c, out_c, cnt_c);
        end
    endtask

    task automatic test_async_reset();
        apply(1'b1, 1'b1, 1'b0);
        apply(1'b0, 1'b1, 1'b0);
        apply(1'b1, 1'b1, 1'b0);
        checks++;
        if (st_a !== 3'd3) begin
            errors++;
            $display("FAIL async_setup: state=%0d required 3", st_a);
        end
        #2 rst = 1'b0;
        #1;
        model_reset();
        checks++;
        if (st_a !== 3'd0 || out_a !== 1'b0 || cnt_a !== 8'd0 || cnt_c !== 2'd0) begin
            errors++;
            $display("FAIL async_reset: a=%0d/%0d/%0d c_cnt=%0d required all 0",
                     st_a, out_a, cnt_a, cnt_c);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int n = 0; n < 4; n++) begin
            apply((n != 1), 1'b1, 1'b0);
            checks++;
            if (st_a !== 3'(e_st[0]) || out_a !== 1'(e_out[0]) || cnt_a !== 8'(e_cnt[0])) begin
                errors++;
                $display("FAIL async_after bit%0d: %0d/%0d/%0d required %0d/%0d/%0d",
                         n + 1, st_a, out_a, cnt_a, e_st[0], e_out[0], e_cnt[0]);
            end
        end
        checks++;
        if (out_a !== 1'b1) begin
            errors++;
            $display("FAIL async_match: out=%0d required 1", out_a);
        end
    endtask

    task automatic test_random();
        logic b, v, c;
        for (int n = 0; n < 400; n++) begin
            b = 1'($urandom_range(1));
            v = ($urandom_range(3) != 0);
            c = ($urandom_range(29) == 0);
            apply(b, v, c);
            checks++;
            if (st_a !== 3'(e_st[0]) || out_a !== 1'(e_out[0]) || cnt_a !== 8'(e_cnt[0]) ||
                st_b !== 3'(e_st[1]) || out_b !== 1'(e_out[1]) || cnt_b !== 8'(e_cnt[1]) ||
                st_c !== 2'(e_st[2]) || out_c !== 1'(e_out[2]) || cnt_c !== 2'(e_cnt[2])) begin
                errors++;
                $display("FAIL random cyc%0d: a=%0d/%0d/%0d b=%0d/%0d/%0d c=%0d/%0d/%0d required a=%0d/%0d/%0d b=%0d/%0d/%0d c=%0d/%0d/%0d",
                         n, st_a, out_a, cnt_a, st_b, out_b, cnt_b, st_c, out_c, cnt_c,
                         e_st[0], e_out[0], e_cnt[0], e_st[1], e_out[1], e_cnt[1],
                         e_st[2], e_out[2], e_cnt[2]);
            end
        end
    endtask

    initial begin
        pw   = '{4, 4, 2};
        ovl  = '{1, 0, 1};
        cmax = '{255, 255, 3};
        pt   = '{16'b1011, 16'b1011, 16'b11};
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_chain();
        test_gaps();
        test_saturation();
        test_clr_priority();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised serial sequence-detector FSM. Successor to the fixed single-pattern Moore detector used in the assignment-1 FSM datapath.
- Accepts one bit per valid cycle and tracks the longest matched prefix of a compile-time PATTERN. Emits a one-cycle match pulse.
- Supports overlapping and non-overlapping detection, and keeps a saturating match counter.
- Exposes its current state for debug and top-level display.

Parameters:
- PAT_W, 4: pattern length in bits; legal range 2..16.
- PATTERN, 4'b1011: target sequence, PAT_W bits. PATTERN[PAT_W-1] is the first bit expected on the line.
- OVERLAP, 1: 1 = overlapping detection; 0 = after a match, matching restarts from the empty prefix.
- CNT_W, 8: width of the match counter.
- SW, $clog2(PAT_W+1): state width; derived, not to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- inp  input  1  serial data bit.
- in_valid  input  1  inp is sampled only on cycles where in_valid=1.
- clr  input  1  synchronous clear of state, out and match_count.
- outputState  output  SW  current state: number of pattern bits matched, 0..PAT_W.
- out  output  1  registered match pulse.
- match_count  output  CNT_W  saturating count of matches since reset or clr.

Behaviour:
- Reset (rst=0, asynchronous): outputState=0, out=0, match_count=0. All outputs are held there while rst is low. The first sample is taken on the first rising clk edge after rst deasserts.
- State meaning: state k means the last k accepted bits equal PATTERN[PAT_W-1 -: k]. State PAT_W means a full match has just completed.
- Transition on a valid cycle (in_valid=1, clr=0):
  - Form s = (prefix of length k) followed by inp.
  - next state = length of the longest suffix of s that is also a prefix of PATTERN (a KMP failure step), capped at PAT_W.
  - From state PAT_W with OVERLAP=0: k is treated as 0 before the new bit is applied.
  - From state PAT_W with OVERLAP=1: the full pattern is used as the prefix, so the failure chain applies.
- Transition on a cycle with in_valid=0: state holds, out=0, match_count holds.
- out: registered, and equals 1 for exactly the one cycle after the edge that moves the state to PAT_W. Equivalently, out is high in the same cycle outputState first reads PAT_W. out is never high two cycles in a row unless consecutive valid bits each complete a match (possible only when the pattern self-overlaps, e.g. PATTERN=11).
- match_count: increments at the same edge that sets out. It saturates at 2^CNT_W-1 with no wrap.
- clr=1: at the next edge, state=0, out=0, match_count=0. clr takes priority over in_valid, and the bit presented that cycle is discarded.
- Latency: a match is visible on out one clk edge after its final bit is sampled.
- Next-state logic is combinational over PAT_W with no multi-cycle search. Implementation uses generate/loop logic driven by PATTERN, so one RTL body covers every legal PAT_W.

Test Plan:
- Defaults, rst low 3 cycles then high; stream 1,0,1,1,0,1,1 all valid → outputState trace 1,2,3,4,2,3,4; out high after bit 4 and after bit 7; match_count=2.
- OVERLAP=0, same stream 1011011 → single match after bit 4, then states 0,1?: trace 1,2,3,4,0,1,1 (011); match_count=1. Stream 10111011 → 2 matches.
- Failure chain: stream 1,0,1,0,1,0,1,1 → states 1,2,3,2,3,2,3,4; exactly one out pulse, after bit 8.
- Valid gaps: bits 1,0 with in_valid, then 3 idle cycles, then 1,1 → state holds at 2 during the idle cycles; out pulses once after the final 1; no pulse during the idle cycles.
- Saturation and clr: CNT_W=2, feed 5 matches → match_count stays 3. Assert clr together with a valid completing bit → state=0, count=0, no out pulse.
- Asynchronous reset mid-stream: drop rst between clock edges while in state 3 → outputState, out and match_count go to 0 immediately without waiting for a clock edge. After release, 1011 → match.
